// File: rtl/mpc_mul_arb_pkg.sv
// Shared constants and the in-flight tag type for the time-shared multiplier.
package mpc_mul_arb_pkg;

  localparam int A_W         = 21;  // signed multiplicand width
  localparam int B_W         = 7;   // unsigned multiplier width
  localparam int P_W         = 29;  // signed product width
  localparam int MUL_LAT_DEF = 3;   // default DSP pipeline depth
  localparam int TAG_ID_W    = 3;   // id field wide enough for up to 8 requesters

  // One in-flight product: who issued it and whether it closes a dot product.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } tag_t;

endpackage

// File: rtl/mpc_rr_arbiter.sv
// Combinational rotate-priority-rotate round-robin arbiter.
// The request vector is rotated so the pointer position becomes bit 0, the
// lowest set bit wins, and the offset is rotated back into a requester index.
module mpc_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W-1:0]    w_off;
  logic               w_hit;
  int                 w_sum;

  // Rotate, priority-pick the lowest set bit, rotate the winner back.
  always_comb begin
    w_dbl = {req, req} >> ptr;
    w_rot = w_dbl[N_REQ-1:0];
    w_off = '0;
    w_hit = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_hit = 1'b1;
        w_off = ID_W'(j);
      end
    end
    w_sum = int'(ptr) + int'(w_off);
    if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
    idx = ID_W'(w_sum);
    gnt = '0;
    if (en && w_hit) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mpc_mul_share_arb.sv
// Round-robin sharing of one pipelined signed x unsigned DSP multiplier.
// Handshake: an operand pair moves on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready never depends on anything but the
// current req_valid, the pointer and ce. Results carry no backpressure: a
// res_valid strobe must be taken in the cycle it is presented.
module mpc_mul_share_arb
  import mpc_mul_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [A_W-1:0]       mul_a,
  output logic [B_W-1:0]       mul_b,
  output logic                 mul_ce,
  input  logic [P_W-1:0]       mul_p,
  output logic [N_REQ-1:0]     res_valid,
  output logic [P_W-1:0]       res_p,
  output logic                 res_last,
  output logic [ID_W-1:0]      res_id,
  output logic                 busy
);

  logic [ID_W-1:0]  r_ptr;
  tag_t             r_tag [MUL_LAT];
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_en;
  tag_t             w_tag_in;
  tag_t             w_tag_out;

  // Grants are suppressed while reset is asserted so no operand is consumed.
  assign w_en = ce & rst_n;

  mpc_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (r_ptr),
    .en  (w_en),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  assign req_ready = w_gnt;
  assign w_any     = |w_gnt;
  assign mul_ce    = ce;

  // Steer the winner's operands to the DSP; zeros when idle keep X out of it.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (w_any) begin
      mul_a = req_a[w_idx*A_W +: A_W];
      mul_b = req_b[w_idx*B_W +: B_W];
    end
  end

  // Tag entering the pipeline alongside the operands.
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_any;
    w_tag_in.id    = TAG_ID_W'(w_idx);
    w_tag_in.last  = req_last[w_idx];
  end

  // Round-robin pointer: one past the winner after every enabled grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (ce && w_any) begin
      r_ptr <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  // Tag shift register kept in lockstep with the DSP pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MUL_LAT; k++) r_tag[k] <= '0;
    end else if (ce) begin
      r_tag[0] <= w_tag_in;
      for (int k = 1; k < MUL_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_tag_out = r_tag[MUL_LAT-1];
  assign res_p     = mul_p;
  assign res_id    = w_tag_out.id[ID_W-1:0];
  assign res_last  = w_tag_out.last;

  // Route the product at the pipeline exit back to its issuer.
  always_comb begin
    res_valid = '0;
    if (ce && w_tag_out.valid) res_valid[w_tag_out.id[ID_W-1:0]] = 1'b1;
  end

  // Anything still travelling through the tag stages keeps busy high.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) busy = busy | r_tag[k].valid;
  end

endmodule

// File: doc/mpc_mul_share_arb.md
Name: mpc_mul_share_arb

Overview:
Round-robin scheduler that time-shares one pipelined 21-bit signed × 7-bit unsigned → 29-bit signed DSP multiplier among N_REQ requesters. The requesters are the MPC matrix-vector product lanes. The block grants at most one operand pair per enabled cycle and drives the multiplier's a/b/ce inputs. It tracks each in-flight product with a tag shift register and routes every result back to its requester along with that requester's "last" flag.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width, equal to clog2(N_REQ)
MUL_LAT, 3, enabled cycles from operands presented on mul_a/mul_b to the product on mul_p

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  global clock enable; all state and the multiplier advance only when ce=1
req_valid  in  N_REQ  per-requester operand valid
req_a  in  N_REQ*21  packed signed operands; requester i occupies bits [21*i+20:21*i]
req_b  in  N_REQ*7  packed unsigned operands; requester i occupies bits [7*i+6:7*i]
req_last  in  N_REQ  marks the final term of a dot product; carried to the output unchanged
req_ready  out  N_REQ  one-hot grant; the operand is consumed at the edge when req_valid[i] & req_ready[i]
mul_a  out  21  signed operand to the multiplier
mul_b  out  7  unsigned operand to the multiplier
mul_ce  out  1  multiplier enable, equal to ce
mul_p  in  29  signed product from the multiplier
res_valid  out  N_REQ  one-hot result strobe
res_p  out  29  product, equal to mul_p
res_last  out  1  last flag of the product being presented
res_id  out  ID_W  requester index of the product being presented
busy  out  1  at least one product in flight

Behaviour:
- Reset (asynchronous, rst_n=0): round-robin pointer=0; all tag stages invalid. Outputs during reset: req_ready=0, res_valid=0, res_last=0, res_id=0, busy=0.
- Arbitration (combinational):
  - Search req_valid starting at the pointer and wrapping modulo N_REQ; the first set bit wins.
  - req_ready[winner]=ce; all other req_ready bits are 0.
  - If nothing is requested or ce=0, req_ready is all zeros.
- Pointer update: on an edge with ce=1 and a grant, pointer←(winner+1) mod N_REQ. Otherwise the pointer holds.
- Issue (combinational):
  - With a grant, mul_a=req_a[winner] and mul_b=req_b[winner].
  - Without a grant, mul_a=0 and mul_b=0, so no X values reach the DSP.
- Tag pipeline: MUL_LAT stages, each holding {valid, id, last}.
  - Stage 0 loads {grant_any, winner, req_last[winner]} on an edge with ce=1.
  - Stage k loads stage k-1 on an edge with ce=1.
  - With ce=0, every stage holds.
- Tag/product alignment: the last tag stage is aligned with mul_p. A product issued at enabled edge E appears on mul_p after MUL_LAT enabled edges.
- Result presentation:
  - res_valid[i] = ce & tag_last.valid & (tag_last.id==i).
  - res_p=mul_p, res_id=tag_last.id, res_last=tag_last.last.
  - Results have no backpressure; the requester must accept any strobed result.
- Throughput and latency:
  - One issue per enabled cycle, full throughput when every enabled cycle has a grant.
  - Each requester gets at least one grant per N_REQ enabled cycles while it holds req_valid.
  - Latency from grant edge to res_valid is exactly MUL_LAT enabled cycles; ce=0 cycles stretch it.
- Arithmetic: product = signed(a) × unsigned(b), sign-extended into 29 bits; overflow is impossible. Range: −1048576×127 = −133169152.
- Ordering: results leave in issue order. For one requester, results return in the order that requester issued them.
- busy = OR over the valid bits of all tag stages.
- Reset mid-operation: in-flight tags are cleared, so stale products left in the unreset DSP registers never raise res_valid. The pointer restarts at 0.
- Simultaneous events: a new grant and a result for the same requester in one cycle are legal and independent. A req_valid deasserted without a handshake is dropped without side effects.

Decomposition:
- Shared package mpc_mul_arb_pkg holds:
  - constants A_W=21, B_W=7, P_W=29, MUL_LAT_DEF=3;
  - a tag typedef {valid, id, last}.
- Sub-module mpc_rr_arbiter: N_REQ-wide rotate-priority-rotate arbiter with inputs req, ptr, en and outputs a one-hot grant and the winner index. It is combinational and reused for other shared MPC resources.
- The multiplier stays outside this block.

Test Plan:
1. Single requester: req0 a=−1000, b=100, last=1, ce=1 → req_ready[0] in cycle 0; res_valid[0], res_p=−100000, res_last=1 after 3 cycles; busy high for exactly those cycles.
2. All 4 requesters valid continuously → grants 0,1,2,3,0,…, one per cycle; results arrive in the same id order with 3-cycle latency; no gaps.
3. Extremes: a=−1048576, b=127 → res_p=−133169152. a=1048575, b=127 → res_p=133169025.
4. ce stall: issue at cycle 0, hold ce=0 for cycles 1–4 → req_ready=0, tags and pointer held, no res_valid while ce=0; result appears on the 3rd enabled edge after the issue.
5. Reset mid-flight: issue 3 products, pulse rst_n low for 1 cycle → no res_valid afterwards; busy=0; next grant goes to the lowest-index active requester (pointer=0).
6. Fairness: req1 and req3 held valid while req0 toggles → no requester waits more than N_REQ enabled cycles for a grant; the id order at the result port matches the issue order.
